// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Latency: done WIDTH+1 edges after start is accepted; one extra IDLE cycle between ops.
// Backpressure: start is sampled only in IDLE; busy is high in RUN/FIX and requests are dropped then.
//
// Ports: clock, reset (async, active high); start/op/a/b launch an operation;
// hi_we/lo_we/wdata write HI/LO directly while idle; busy, done, hi, lo report status/results;
// div_zero exists only when DIVZERO_EXC_EN is defined (divide-by-zero fast exit).
// Optional feature macro: DIVZERO_EXC_EN.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef DIVZERO_EXC_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      iterCnt;
  logic               isDiv;
  logic               negLo;     // sign of product / quotient
  logic               negHi;     // sign of remainder (dividend sign) or product
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;       // {upper, lower}: product, or {remainder, quotient}
`ifdef DIVZERO_EXC_EN
  logic               dzPend;
`endif

  // op[0] = 1 selects unsigned variants
  logic signedOp, aNeg, bNeg;
  assign signedOp = ~op[0];
  assign aNeg     = signedOp & a[WIDTH-1];
  assign bNeg     = signedOp & b[WIDTH-1];

  function automatic logic [WIDTH-1:0] magOf(input logic [WIDTH-1:0] x, input logic neg);
    // -MIN wraps to MIN, whose unsigned reading is the correct magnitude
    return neg ? (~x + 1'b1) : x;
  endfunction

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     remShift;
  logic [WIDTH:0]     remDiff;
  logic               remGeq;
  logic [2*WIDTH-1:0] divNext;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoMag, remMag, quoFix, remFix;

  always_comb begin
    // Shift-add: add multiplicand into the upper half when the current multiplier bit is set,
    // then shift the whole accumulator right; the carry lands in the top bit.
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mulNext  = {mulSum, acc[WIDTH-1:1]};
    // Restoring divide: bring next dividend bit into the remainder, subtract if it fits.
    // The remainder stays below the divisor, so one extra bit covers the shifted value.
    remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    remDiff  = remShift - {1'b0, opnd};
    remGeq   = (remShift >= {1'b0, opnd});
    divNext  = {(remGeq ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0]), acc[WIDTH-2:0], remGeq};
    // Sign correction applied in FIX
    prodFix  = negLo ? (~acc + 1'b1) : acc;
    quoMag   = acc[WIDTH-1:0];
    remMag   = acc[2*WIDTH-1:WIDTH];
    quoFix   = negLo ? (~quoMag + 1'b1) : quoMag;
    remFix   = negHi ? (~remMag + 1'b1) : remMag;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      iterCnt <= '0;
      isDiv   <= 1'b0;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef DIVZERO_EXC_EN
      dzPend   <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DIVZERO_EXC_EN
      div_zero <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Direct writes land even when a start is accepted this cycle;
          // the completing operation overwrites them later.
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            isDiv   <= op[1];
            negLo   <= aNeg ^ bNeg;
            negHi   <= op[1] ? aNeg : (aNeg ^ bNeg);
            opnd    <= magOf(b, bNeg);
            acc     <= {{WIDTH{1'b0}}, magOf(a, aNeg)};
            iterCnt <= '0;
            busy    <= 1'b1;
`ifdef DIVZERO_EXC_EN
            if (op[1] && (b == '0)) begin
              state  <= FIX;
              dzPend <= 1'b1;
            end else begin
              state  <= RUN;
              dzPend <= 1'b0;
            end
`else
            state   <= RUN;
`endif
          end
        end
        RUN: begin
          acc     <= isDiv ? divNext : mulNext;
          iterCnt <= iterCnt + 1'b1;
          if (iterCnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
`ifdef DIVZERO_EXC_EN
          if (dzPend) begin
            div_zero <= 1'b1;
          end else if (isDiv) begin
            hi <= remFix;
            lo <= quoFix;
          end else begin
            {hi, lo} <= prodFix;
          end
`else
          if (isDiv) begin
            hi <= remFix;
            lo <= quoFix;
          end else begin
            {hi, lo} <= prodFix;
          end
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH = 32, default configuration).
// Latency: checks done WIDTH+1 edges after accept.
// Backpressure: checks start/direct writes are ignored while busy.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic         clock;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         hi_we, lo_we;
  logic [W-1:0] wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int compared   = 0;
  int mismatched = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request for one edge, then scramble the operands.
  task automatic startOp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Bounded wait for done; n = edges waited.
  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] expHi, input logic [W-1:0] expLo);
    int n;
    startOp(o, x, y);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    waitDone(n);
    check({tag, "_lat"}, 64'(n), 64'd33);
    check({tag, "_hilo"}, {hi, lo}, {expHi, expLo});
  endtask

  initial begin
    int n;
    int doneSeen;
    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;

    // Reset acts before any clock edge
    #1 reset = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Direct writes while idle
    hi_we = 1'b1; wdata = 32'h0000AAAA;
    tick();
    hi_we = 1'b0;
    check("mthi", {hi, lo}, {32'h0000AAAA, 32'h0});
    lo_we = 1'b1; wdata = 32'h00005555;
    tick();
    lo_we = 1'b0;
    check("mtlo", {hi, lo}, {32'h0000AAAA, 32'h00005555});

    runOp("mult_m2x3", OP_MULT, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    check("mult_m2x3_done", 64'(done), 64'd1);
    tick();
    check("done_pulse", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    runOp("div_m7_2",    OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("divu_m7_2",   OP_DIVU,  32'hFFFFFFF9, 32'h2,        32'h00000001, 32'h7FFFFFFC);
    runOp("div_min_m1",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    runOp("multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    runOp("mult_minmin", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    runOp("mult_7xm3",   OP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    runOp("div_7_m2",    OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    runOp("divu_by0",    OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF);
    runOp("div_m5_by0",  OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'h00000001);

    // start and direct writes during RUN are ignored
    startOp(OP_MULT, 32'd5, 32'd6);
    repeat (5) tick();
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd0;
    tick();
    start = 1'b0;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h00001234;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    check("busy_wr_ign", {hi, lo}, {32'hFFFFFFFB, 32'h00000001});
    waitDone(n);
    check("busy_lat", 64'(n), 64'd26);
    check("busy_res", {hi, lo}, {32'h0, 32'd30});

    // Back-to-back start in the done cycle
    check("b2b_done", 64'(done), 64'd1);
    runOp("b2b_divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    tick();

    // Direct write coincident with accepted start
    hi_we = 1'b1; wdata = 32'h00000077;
    startOp(OP_MULTU, 32'd2, 32'd3);
    hi_we = 1'b0;
    check("wr_start_hi", 64'(hi), 64'h77);
    waitDone(n);
    check("wr_start_lat", 64'(n), 64'd33);
    check("wr_start_res", {hi, lo}, {32'h0, 32'd6});
    tick();

    // Reset mid-RUN
    startOp(OP_MULT, 32'h11, 32'h22);
    repeat (10) tick();
    check("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_hilo", {hi, lo}, 64'd0);
    #2 reset = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) doneSeen++;
    end
    check("post_rst_nodone", 64'(doneSeen), 64'd0);
    runOp("post_rst_multu", OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width; legal values even integers 4..64.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 a, b  input  WIDTH each  operands: multiplicand/multiplier or dividend/divisor.
REQ-007 hi_we, lo_we  input  1 each  direct HI/LO write enables (mthi/mtlo).
REQ-008 wdata  input  WIDTH  direct-write data.
REQ-009 busy  output  1  high in RUN and FIX.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 hi, lo  output  WIDTH each  registered HI/LO contents.
REQ-012 div_zero  output  1  divide-by-zero flag; exists only with DIVZERO_EXC_EN.

Function
REQ-013 FSM states IDLE, RUN, FIX; IDLE->RUN on start, RUN->FIX when iteration counter reaches WIDTH, FIX->IDLE unconditionally.
REQ-014 On accept, operands and op latched; signed ops convert operands to magnitudes and record result signs.
REQ-015 RUN performs one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle, exactly WIDTH cycles.
REQ-016 FIX applies sign correction, writes HI/LO, asserts done; done visible WIDTH+1 rising edges after the accepting edge, low otherwise.
REQ-017 Multiply: {hi,lo} = full 2*WIDTH product, signed or unsigned per op.
REQ-018 Divide: lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes sign of dividend.
REQ-019 Signed MIN / -1: lo = MIN (wrap), hi = 0, no flag.
REQ-020 start while busy: ignored, no queuing, in-flight operation unaffected.
REQ-021 start in the IDLE cycle where done is high: accepted normally (back-to-back, WIDTH+2 cycles per op).
REQ-022 hi_we/lo_we take effect only while busy is low; ignored while busy.
REQ-023 Direct write and accepted start in same cycle: write applies; completion later overwrites HI/LO.
REQ-024 Operands a, b may change after acceptance without affecting result.

Reset
REQ-025 reset asserted: state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, div_zero 0, immediately, independent of clock.
REQ-026 reset mid-operation abandons it; no done pulse follows; first start after release is accepted normally.

Configuration
REQ-027 Macro DIVZERO_EXC_EN: defined -> DIV/DIVU with b = 0 skips RUN, goes to FIX next cycle, leaves HI/LO unchanged, asserts done and div_zero together for one cycle (latency 2 edges).
REQ-028 DIVZERO_EXC_EN undefined -> no div_zero port; b = 0 runs full WIDTH+1 latency, result lo = all ones (unsigned) or -1/+1 per sign rule from all-ones magnitude, hi = a.

Verification (WIDTH = 32)
REQ-029 MULT a=0xFFFFFFFE (-2), b=0x00000003 -> after 33 edges done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-030 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU same operands -> lo=0x7FFFFFFC, hi=1.
REQ-031 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 start pulsed at cycle 5 of RUN and hi_we with wdata=0x1234 mid-RUN -> both ignored; first result unchanged; back-to-back start on done cycle accepted.
REQ-033 reset asserted at RUN cycle 10 -> busy/done/hi/lo 0 immediately; no done pulse for 40 cycles.
REQ-034 DIVU b=0 with DIVZERO_EXC_EN, hi=0xA, lo=0xB preloaded -> done and div_zero high 2 edges after start, hi=0xA, lo=0xB.
